piso_arb_ctrl: RTL
==================

Name: piso_arb_ctrl

Overview:
Two-requester round-robin scheduler that shares one serial output lane.
- Each requester offers a WIDTH-bit parallel word on a valid/ready handshake.
- The block grants one requester, captures the word into an internal shift register and shifts it out LSB first, one bit per clock, with bit-valid and last-bit strobes.
- It sits between parallel producers and a single-wire serial link, sequencing load/shift the same way a standalone parallel-in/serial-out register is driven.

Parameters:
- WIDTH, 4: bits per word and shift cycles per frame; legal range 2..16.
- GAP, 1: idle cycles inserted after each frame before the next grant; legal range 0..15.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req0_valid, input, 1: requester 0 has a word.
- req0_data, input, WIDTH: requester 0 word.
- req0_ready, output, 1: requester 0 word accepted this cycle if valid.
- req1_valid, input, 1: requester 1 has a word.
- req1_data, input, WIDTH: requester 1 word.
- req1_ready, output, 1: requester 1 word accepted this cycle if valid.
- s_out, output, 1: serial data, LSB first.
- s_valid, output, 1: s_out carries a frame bit this cycle.
- s_last, output, 1: current bit is bit WIDTH-1 of the frame.
- grant_id, output, 1: requester that owns the current or last frame.
- busy, output, 1: high in SHIFT and GAP.

Behaviour:
- Reset while rst_n=0:
  - state=IDLE, sreg=0, bit counter=0, gap counter=0, rr pointer=0 (req0 preferred).
  - s_out=0, s_valid=0, s_last=0, busy=0, grant_id=0.
  - req0_ready=req1_ready=0, forced low even though the state is IDLE.
- Shift register: WIDTH-bit sreg; s_out = sreg[0].
- State machine:
  - IDLE → SHIFT when a handshake occurs; otherwise stay in IDLE.
  - SHIFT → GAP at the edge ending bit WIDTH-1 when GAP>0; → IDLE at that edge when GAP=0.
  - GAP → IDLE after GAP cycles.
- Arbitration (combinational, IDLE only):
  - sel = the only valid requester.
  - If both are valid, sel = rr pointer.
  - reqN_ready = (state==IDLE) && (sel==N) && valid present. Ready may depend on valid; valid must not depend on ready.
  - Ready is low in SHIFT and GAP.
- Handshake edge (valid && ready):
  - sreg ← selected data; grant_id ← sel; rr pointer ← ~sel; bit counter ← 0; state ← SHIFT.
  - The unselected requester's data is ignored; it must hold valid until it is served.
- SHIFT:
  - s_valid=1, busy=1.
  - s_last = (bit counter == WIDTH-1).
  - Each edge: sreg shifts right with 0 fill, counter increments.
  - Frame bits appear in the WIDTH cycles immediately after the accept edge: d[0], d[1], …, d[WIDTH-1].
- GAP: s_valid=0, s_last=0, busy=1, s_out=0 (sreg fully shifted), gap counter counts to GAP.
- IDLE: s_valid=0, s_last=0, busy=0.
- Throughput: at least one IDLE cycle per frame, so the minimum frame period is WIDTH+GAP+1 cycles. Consecutive accepts are exactly WIDTH+GAP+1 cycles apart under continuous requests.
- Fairness: under continuous requests from both sides, grants alternate 0,1,0,1. A single active requester is granted every frame regardless of the pointer.
- Valid dropped before ready: no transfer, no state change.
- Reset mid-frame:
  - Frame aborts immediately; s_valid/s_last drop asynchronously.
  - No s_last is emitted for the aborted frame; the pointer returns to 0.
  - The aborted word is lost; the requester has already seen its handshake.
- grant_id holds its value through IDLE until the next accept.

Test Plan:
1. Reset, then req0_valid=1 with req0_data=4'b1010 (WIDTH=4, GAP=1) → req0_ready=1 in the first IDLE cycle. The next 4 cycles give s_out=0,1,0,1 with s_valid=1 and s_last only on the 4th. Then busy=1 for 1 GAP cycle, and ready returns one cycle later.
2. Both valid continuously, req0_data=4'b1111, req1_data=4'b0000 → accepts 6 cycles apart. grant_id=0,1,0,1; s_out frames alternate 1111, 0000; ready is never asserted to both in the same cycle.
3. Only req1 valid for 3 frames with 4'b1100 → three grants to req1, each serialising 0,0,1,1. req0_ready stays 0 throughout.
4. GAP=0 build, req0 continuous with 4'b0011 → frames every 5 cycles. Exactly one IDLE cycle (s_valid=0) separates each s_last from the next first bit.
5. rst_n pulled low after the 2nd bit of 4'b1010 → s_out, s_valid, s_last and busy drop to 0 asynchronously, with no s_last. After release with both valid, req0 is granted first.
6. req0_valid pulsed high only during SHIFT, low in IDLE → no accept. State stays IDLE; s_valid=0.

Source files
------------

// File: rtl/piso_arb_ctrl_if.sv
// Bundle of requester handshakes and the serial output lane for piso_arb_ctrl.
// The slave modport is the scheduler itself; master is whoever drives requests
// and listens to the serial lane.
interface piso_arb_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             s_out;
    logic             s_valid;
    logic             s_last;
    logic             grant_id;
    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, s_out, s_valid, s_last, grant_id, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, s_out, s_valid, s_last, grant_id, busy
    );
endinterface

// File: rtl/piso_arb_ctrl.sv
// Two-requester round-robin scheduler feeding one serial lane.
// A granted word is loaded into a shift register and sent LSB first, one bit
// per clock, followed by GAP idle cycles and at least one IDLE cycle.
module piso_arb_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    piso_arb_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             rr_ptr;
    logic             grant_q;
    logic             sel;
    logic             any_valid;
    logic             accept;

    // Pick a requester while idle: a lone requester wins outright, a tie goes to the pointer.
    // Ready is also gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        sel       = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            sel = rr_ptr;
        end else if (bus.req1_valid) begin
            sel = 1'b1;
        end
        accept         = rst_n && (state == ST_IDLE) && any_valid;
        bus.req0_ready = accept && !sel;
        bus.req1_ready = accept && sel;
    end

    // Next-state logic and the state-decoded serial strobes.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        bus.s_valid  = (state == ST_SHIFT);
        bus.s_last   = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
        bus.busy     = (state != ST_IDLE);
        bus.s_out    = sreg[0];
        bus.grant_id = grant_q;
    end

    // State register; reset aborts any frame in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Load on accept, shift right with zero fill during SHIFT, count gap cycles during GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            rr_ptr  <= 1'b0;
            grant_q <= 1'b0;
        end else if (accept) begin
            sreg    <= sel ? bus.req1_data : bus.req0_data;
            grant_q <= sel;
            rr_ptr  <= ~sel;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (state == ST_SHIFT) begin
            sreg    <= sreg >> 1;
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            gap_cnt <= '0;
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end
endmodule
